// File: rtl/mux4_scan_pkg.sv
// Shared types and widths for the 4:1 mux scanner.
package mux4_scan_pkg;

   localparam int SEL_W  = 2;
   localparam int WORD_W = 4;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/mux4_scanner_if.sv
// Result handshake between the scanner (master) and its consumer (slave).
// valid/ready: the master raises out_valid with out_data and holds both
// unchanged until a rising edge where out_valid & out_ready are both high;
// that edge transfers the word. out_valid never depends on out_ready.
interface mux4_scanner_if;
   import mux4_scan_pkg::*;

   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_data;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/mux4_scanner_settle_timer.sv
// Counts the idle cycles a new mux select needs before it may be sampled.
// load clears the count; while en is high the count advances and done
// pulses on the last settle cycle. The count saturates instead of wrapping.
module settle_timer
   import mux4_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign done = en && (cnt_q == LAST);

   // Next count: clear on load or when idle, advance until the last cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (!en) begin
         cnt_d = '0;
      end else if (!done) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mux4_scanner.sv
// Walks a downstream 4:1 mux through selects 0..3, waits for each select to
// settle, samples the read-back bit and presents the assembled word on a
// valid/ready port. All outputs are registered.
module mux4_scanner
   import mux4_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic [SEL_W-1:0] mux_sel,
   input  logic             mux_out,
   output logic             busy,
   output logic             start_drop,
   mux4_scanner_if.master   out_if,
   output state_t           dbg_state
);

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WORD_W - 1);

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  mux_sel_q, mux_sel_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [WORD_W-1:0] out_data_q, out_data_d;
   logic              busy_q, busy_d;
   logic              out_valid_q, out_valid_d;
   logic              start_drop_q, start_drop_d;
   logic              tmr_load, tmr_en, tmr_done;

   settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tmr_load),
      .en    (tmr_en),
      .done  (tmr_done)
   );

   // Timer restarts on every entry into SETTLE and runs only while there.
   assign tmr_load = (state_d == SETTLE) && (state_q != SETTLE);
   assign tmr_en   = (state_q == SETTLE);

   // Next-state logic; abort overrides start and the handshake.
   always_comb begin
      state_d      = state_q;
      mux_sel_d    = mux_sel_q;
      word_d       = word_q;
      start_drop_d = start_drop_q;

      if (abort) begin
         state_d      = IDLE;
         mux_sel_d    = '0;
         word_d       = '0;
         start_drop_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d   = SETTLE;
                  mux_sel_d = '0;
                  word_d    = '0;
               end
            end
            SETTLE: begin
               if (start) start_drop_d = 1'b1;
               if (tmr_done) state_d = SAMPLE;
            end
            SAMPLE: begin
               if (start) start_drop_d = 1'b1;
               word_d[mux_sel_q] = mux_out;
               if (mux_sel_q == LAST_SEL) begin
                  state_d = DONE;
               end else begin
                  state_d   = SETTLE;
                  mux_sel_d = mux_sel_q + 1'b1;
               end
            end
            DONE: begin
               if (out_if.out_ready) begin
                  mux_sel_d = '0;
                  word_d    = '0;
                  state_d   = start ? SETTLE : IDLE;
               end else if (start) begin
                  start_drop_d = 1'b1;
               end
            end
            default: begin
               state_d   = IDLE;
               mux_sel_d = '0;
            end
         endcase
      end

      // Registered outputs follow the next state.
      busy_d      = (state_d == SETTLE) || (state_d == SAMPLE);
      out_valid_d = (state_d == DONE);
      if (state_d == DONE) begin
         out_data_d = (state_q == DONE) ? out_data_q : word_d;
      end else begin
         out_data_d = '0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         mux_sel_q    <= '0;
         word_q       <= '0;
         out_data_q   <= '0;
         busy_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         start_drop_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mux_sel_q    <= mux_sel_d;
         word_q       <= word_d;
         out_data_q   <= out_data_d;
         busy_q       <= busy_d;
         out_valid_q  <= out_valid_d;
         start_drop_q <= start_drop_d;
      end
   end

   assign mux_sel          = mux_sel_q;
   assign busy             = busy_q;
   assign start_drop       = start_drop_q;
   assign out_if.out_valid = out_valid_q;
   assign out_if.out_data  = out_data_q;
   assign dbg_state        = state_q;

endmodule

// File: doc/mux4_scanner.md
MUX4_SCANNER -- requirements
Module: mux4_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of idle cycles after each select change before sampling (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a 4-bit scan.
REQ-005 SHALL have port abort  input  1  synchronous cancel of any scan or pending result.
REQ-006 SHALL have port mux_sel  output  2  select driven to the downstream 4:1 mux.
REQ-007 SHALL have port mux_out  input  1  combinational mux output, read back.
REQ-008 SHALL have port busy  output  1  high while in SETTLE or SAMPLE.
REQ-009 SHALL have port out_valid  output  1  assembled word available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the word.
REQ-011 SHALL have port out_data  output  4  assembled word; bit i = mux_out sampled with mux_sel=i.
REQ-012 SHALL have port start_drop  output  1  sticky flag: a start was discarded.

Function
REQ-013 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE: mux_sel=0, busy=0, out_valid=0; start=1 -> SETTLE with mux_sel=0, settle count cleared.
REQ-015 SETTLE: hold mux_sel for exactly SETTLE_CYCLES cycles, then -> SAMPLE.
REQ-016 SAMPLE: capture mux_out into word bit [mux_sel]; if mux_sel=3 -> DONE, else mux_sel+1 -> SETTLE.
REQ-017 out_valid SHALL rise 4*(SETTLE_CYCLES+1) rising edges after the edge that sampled start (8 edges at default).
REQ-018 DONE: out_valid=1, out_data stable until the handshake edge (out_valid & out_ready).
REQ-019 Handshake edge without start -> IDLE; with start in the same cycle -> SETTLE directly, new scan, no bubble.
REQ-020 start in SETTLE or SAMPLE, or in DONE without out_ready, SHALL be ignored and set start_drop.
REQ-021 abort SHALL take priority over start and out_ready: -> IDLE, word discarded, out_valid low next cycle, start_drop cleared.
REQ-022 out_data SHALL read 0 outside DONE.
REQ-023 Settle counter SHALL be 4 bits, wrap-free; mux_sel increments only in SAMPLE, never wraps past 3.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, mux_sel=0, busy=0, out_valid=0, out_data=0, start_drop=0, counter=0.
REQ-025 Reset mid-scan SHALL discard partial word; first start after release begins a fresh scan.

Structure
REQ-026 Shared package mux4_scan_pkg SHALL hold the state enum, SEL_W=2, WORD_W=4, CNT_W=4.
REQ-027 Settle counting SHALL live in sub-module settle_timer (load, done pulse); the FSM and word register stay in mux4_scanner.

Verification
REQ-028 Mux data 4'b0110, start pulse, out_ready=1, default parameter -> out_valid at edge 8, out_data=4'b0110, returns to IDLE.
REQ-029 Data 4'b1001, out_ready=0 for 5 cycles -> out_valid and out_data=4'b1001 held 5 cycles, accepted on the 6th.
REQ-030 start at cycles 2 and 4 of a scan -> both ignored, start_drop=1, single result produced.
REQ-031 abort in SAMPLE with mux_sel=2 -> IDLE next cycle, no out_valid, start_drop=0.
REQ-032 rst_n low during SETTLE with mux_sel=1 -> all outputs 0 immediately; new start after release yields correct word.
REQ-033 SETTLE_CYCLES=3, data 4'b1111, start with out_ready held and start re-asserted on the handshake -> out_valid at edge 16, back-to-back scan with no idle cycle.
